// File: rtl/simd_cmp_seq.sv
// Four-lane signed 32-bit comparator evaluated one lane per cycle through a shared subtractor.
// START accepted at edge T gives DONE during the fifth cycle after T; START is ignored while busy.
module simd_cmp_seq (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [127:0] A,
    input  logic [127:0] B,
    input  logic [2:0]   F,
    output logic         BUSY,
    output logic         DONE,
    output logic [3:0]   MASK,
    output logic         ANY,
    output logic         ALL
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [1:0]   lane_q,  lane_d;
    logic [127:0] a_q,     a_d;
    logic [127:0] b_q,     b_d;
    logic [2:0]   f_q,     f_d;
    logic [3:0]   mask_q,  mask_d;

    logic [31:0] a_lane;
    logic [31:0] b_lane;
    logic [32:0] diff;
    logic        lane_neg;
    logic        lane_zero;
    logic        lane_res;
    logic        accept;

    // Sign-extending to 33 bits keeps the true sign even when the 32-bit difference overflows.
    assign a_lane    = a_q[{lane_q, 5'b0} +: 32];
    assign b_lane    = b_q[{lane_q, 5'b0} +: 32];
    assign diff      = {a_lane[31], a_lane} - {b_lane[31], b_lane};
    assign lane_neg  = diff[32];
    assign lane_zero = (diff[31:0] == 32'd0);
    assign lane_res  = (~lane_zero & ~lane_neg & f_q[0])
                     | (lane_neg & f_q[2])
                     | (lane_zero & f_q[1]);

    assign accept = START && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_RUN;
                    lane_d  = 2'd0;
                    a_d     = A;
                    b_d     = B;
                    f_d     = F;
                    mask_d  = 4'b0000;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                mask_d[lane_q] = lane_res;
                lane_d         = lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                lane_d  = 2'd0;
                mask_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            lane_q  <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            mask_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            mask_q  <= mask_d;
        end
    end

    assign BUSY = (state_q == S_RUN);
    assign DONE = (state_q == S_DONE);
    assign MASK = mask_q;
    assign ANY  = |mask_q;
    assign ALL  = &mask_q;

endmodule

// File: tb/tb_simd_cmp_seq.sv
// Directed bench for simd_cmp_seq: a cycle-countdown reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_simd_cmp_seq;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic [127:0] A;
    logic [127:0] B;
    logic [2:0]   F;
    logic         BUSY;
    logic         DONE;
    logic [3:0]   MASK;
    logic         ANY;
    logic         ALL;

    int checks = 0;
    int errors = 0;

    simd_cmp_seq dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .A     (A),
        .B     (B),
        .F     (F),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .MASK  (MASK),
        .ANY   (ANY),
        .ALL   (ALL)
    );

    always #5 CLK = ~CLK;

    // Model: remain counts cycles to the end of an operation (5 = just accepted, 1 = DONE cycle).
    int           remain = 0;
    logic [127:0] la = '0;
    logic [127:0] lb = '0;
    logic [2:0]   lf = '0;
    logic [3:0]   exp_mask = 4'b0000;

    function automatic logic [3:0] ref_mask(input logic [127:0] a, input logic [127:0] b,
                                            input logic [2:0] f);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            int signed ai;
            int signed bi;
            ai = a[32*i +: 32];
            bi = b[32*i +: 32];
            m[i] = ((ai > bi) & f[0]) | ((ai == bi) & f[1]) | ((ai < bi) & f[2]);
        end
        return m;
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            remain   = 0;
            exp_mask = 4'b0000;
        end else if (START && remain <= 1) begin
            la     = A;
            lb     = B;
            lf     = F;
            remain = 5;
        end else if (remain > 0) begin
            remain = remain - 1;
            if (remain == 1) exp_mask = ref_mask(la, lb, lf);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        chk("model busy", {31'd0, BUSY}, {31'd0, (remain >= 2)});
        chk("model done", {31'd0, DONE}, {31'd0, (remain == 1)});
        if (remain <= 1) begin
            chk("model mask", {28'd0, MASK}, {28'd0, exp_mask});
            chk("model any",  {31'd0, ANY},  {31'd0, |exp_mask});
            chk("model all",  {31'd0, ALL},  {31'd0, &exp_mask});
        end
    endtask

    task automatic start_op(input logic [127:0] a, input logic [127:0] b, input logic [2:0] f);
        A = a;
        B = b;
        F = f;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    // Counts falling edges after the accepting edge until DONE; a bound miss is a failure.
    task automatic wait_done(input bit churn, output int lat);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            lat++;
            if (DONE === 1'b1) return;
            if (churn) begin
                A = {$urandom, $urandom, $urandom, $urandom};
                B = {$urandom, $urandom, $urandom, $urandom};
                F = 3'($urandom_range(0, 7));
            end
        end
        lat = -1;
    endtask

    task automatic run_lit(input string nm, input logic [127:0] a, input logic [127:0] b,
                           input logic [2:0] f, input logic [3:0] m);
        int lat;
        start_op(a, b, f);
        wait_done(1'b0, lat);
        chk({nm, " latency"}, lat, 32'd5);
        chk({nm, " mask"}, {28'd0, MASK}, {28'd0, m});
        chk({nm, " any"},  {31'd0, ANY},  {31'd0, |m});
        chk({nm, " all"},  {31'd0, ALL},  {31'd0, &m});
    endtask

    localparam logic [127:0] OPA = {32'h7FFFFFFF, 32'h00000007, 32'hFFFFFFFD, 32'h00000005};
    localparam logic [127:0] OPB = {32'h80000000, 32'h00000009, 32'hFFFFFFFD, 32'h00000003};

    initial begin
        int lat;
        int dones;
        RESET = 1'b1;
        START = 1'b0;
        A = '0;
        B = '0;
        F = '0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("reset busy", {31'd0, BUSY}, 32'd0);
        chk("reset done", {31'd0, DONE}, 32'd0);
        chk("reset mask", {28'd0, MASK}, 32'd0);
        chk("reset any",  {31'd0, ANY},  32'd0);
        chk("reset all",  {31'd0, ALL},  32'd0);

        fork
            forever begin
                @(negedge CLK);
                model_compare();
            end
        join_none

        run_lit("gt",   OPA, OPB, 3'b001, 4'b1001);
        run_lit("lt",   OPA, OPB, 3'b100, 4'b0100);
        run_lit("eq",   OPA, OPB, 3'b010, 4'b0010);
        run_lit("le",   OPA, OPB, 3'b110, 4'b0110);
        run_lit("none", OPA, OPB, 3'b000, 4'b0000);
        run_lit("all3", OPA, OPB, 3'b111, 4'b1111);
        run_lit("ovf",  {96'd0, 32'h80000000}, {96'd0, 32'h00000001}, 3'b100, 4'b0001);
        repeat (3) @(negedge CLK);
        chk("hold mask", {28'd0, MASK}, 32'h1);

        // START held high: back-to-back operations, one DONE every five cycles.
        A = {4{32'h12345678}};
        B = {4{32'h12345678}};
        F = 3'b010;
        START = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge CLK);
            #1;
            if (i == 19) START = 1'b0;
            @(negedge CLK);
            if (DONE === 1'b1) dones++;
            if (i == 19) begin
                chk("cont mask", {28'd0, MASK}, 32'hF);
                chk("cont all",  {31'd0, ALL},  32'd1);
            end
        end
        chk("cont done count", dones, 32'd4);

        // Reset sampled two edges after acceptance aborts the operation.
        start_op(OPA, OPB, 3'b001);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort busy", {31'd0, BUSY}, 32'd0);
        chk("abort mask", {28'd0, MASK}, 32'd0);
        dones = 0;
        repeat (8) begin
            @(negedge CLK);
            if (DONE === 1'b1) dones++;
        end
        chk("abort no done", dones, 32'd0);
        run_lit("after abort", OPA, OPB, 3'b001, 4'b1001);

        // Reset and START together: reset wins.
        @(posedge CLK);
        #1;
        A = OPA;
        B = OPB;
        F = 3'b111;
        RESET = 1'b1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        chk("rst+start busy", {31'd0, BUSY}, 32'd0);
        chk("rst+start mask", {28'd0, MASK}, 32'd0);
        repeat (2) @(negedge CLK);
        chk("rst+start idle", {31'd0, BUSY}, 32'd0);

        // Inputs churn every cycle while the operation is in flight.
        start_op(OPA, OPB, 3'b001);
        wait_done(1'b1, lat);
        chk("churn latency", lat, 32'd5);
        chk("churn mask", {28'd0, MASK}, 32'h9);
        repeat (3) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_cmp_seq.md
SIMD_CMP_SEQ -- requirements
Module: simd_cmp_seq

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: CLK  in  1  rising-edge clock; RESET  in  1  synchronous active-high reset.
REQ-002 SHALL have port START  in  1  request to begin a 4-lane compare.
REQ-003 SHALL have port A  in  128  packed operand A, lane i = A[32i+31:32i], two's complement.
REQ-004 SHALL have port B  in  128  packed operand B, same lane packing as A.
REQ-005 SHALL have port F  in  3  condition select: F[0]=GT, F[1]=EQ, F[2]=LT; bits OR together.
REQ-006 SHALL have port BUSY  out  1  high while lanes are being evaluated.
REQ-007 SHALL have port DONE  out  1  one-cycle pulse when MASK is final.
REQ-008 SHALL have port MASK  out  4  per-lane condition result, bit i = lane i.
REQ-009 SHALL have port ANY  out  1  OR of MASK, valid with MASK.
REQ-010 SHALL have port ALL  out  1  AND of MASK, valid with MASK.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL accept START only in IDLE or DONE; on acceptance, latch A, B, F, clear lane counter to 0, clear MASK to 0, enter RUN.
REQ-013 SHALL ignore START while in RUN; latched operands unchanged.
REQ-014 SHALL evaluate exactly one lane per RUN cycle, lane 0 first, using one shared subtract/condition path.
REQ-015 Per lane: S = Ai - Bi (32-bit wrap); NEG = bit 32 of sign-extended 33-bit (Ai - Bi), i.e. true signed Ai < Bi with overflow corrected.
REQ-016 Lane result SHALL be (S!=0 & ~NEG & F[0]) | (NEG & F[2]) | (S==0 & F[1]), written to MASK[lane] at end of that cycle.
REQ-017 Lane counter SHALL be 2 bits; after lane 3 is evaluated FSM SHALL go RUN -> DONE (no wrap to lane 0).
REQ-018 Latency: START accepted at edge T -> RUN cycles T+1..T+4 -> DONE=1 during cycle T+5 only.
REQ-019 DONE -> IDLE after one cycle unless START=1 in DONE, then DONE -> RUN directly (back-to-back, new operands latched).
REQ-020 BUSY SHALL be 1 exactly in RUN; DONE SHALL be 1 exactly in DONE.
REQ-021 MASK, ANY, ALL SHALL hold last completed result from DONE until next START acceptance; between acceptance and next DONE they are don't-care for consumers but MASK SHALL be built in place from 0.
REQ-022 F=000 SHALL yield MASK=0000; F=111 SHALL yield MASK=1111.
REQ-023 Changes on A, B, F after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-024 RESET=1 at a rising edge SHALL force IDLE, lane counter 0, MASK=0000, BUSY=0, DONE=0, ANY=0, ALL=0, regardless of state.
REQ-025 RESET asserted mid-RUN SHALL abort the operation; no DONE pulse SHALL follow for the aborted request.
REQ-026 RESET and START high at the same edge: RESET wins; START ignored.

Verification
REQ-027 Lanes A={5,-3,7,0x7FFFFFFF}, B={3,-3,9,0x80000000}, F=001 (GT) -> DONE at T+5, MASK=1001, ANY=1, ALL=0.
REQ-028 Same operands, F=100 (LT) -> MASK=0100; F=010 (EQ) -> MASK=0010; F=110 (LE) -> MASK=0110.
REQ-029 Overflow lane A=0x80000000, B=1, F=100 -> lane bit 1 (signed less) despite wrapped S=0x7FFFFFFF.
REQ-030 START held high continuously with F=010, all lanes equal -> DONE every 5 cycles, MASK=1111, ALL=1; START pulses during RUN produce no extra DONE.
REQ-031 RESET at T+2 of a run -> next cycle IDLE, BUSY=0, MASK=0000, no DONE pulse; new START afterwards completes normally.
REQ-032 Change A/B/F every cycle during RUN -> MASK equals value computed from operands latched at acceptance.
